// File: rtl/cpu_pkg.sv
// cpu_pkg: shared branch types, ARM condition codes and NZCV bit positions
package cpu_pkg;
    typedef enum logic [1:0] {BR_NONE, BR_B, BR_CBZ, BR_COND} br_type_e;
    localparam logic [3:0] EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3;
    localparam logic [3:0] MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7;
    localparam logic [3:0] HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB;
    localparam logic [3:0] GT = 4'hC, LE = 4'hD, AL = 4'hE;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition-code check against an NZCV flag set
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);
    logic n, z, c, v;
    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];
    always_comb begin
        case (cond)
            EQ:      taken = z;
            NE:      taken = ~z;
            HS:      taken = c;
            LO:      taken = ~c;
            MI:      taken = n;
            PL:      taken = ~n;
            VS:      taken = v;
            VC:      taken = ~v;
            HI:      taken = c & ~z;
            LS:      taken = ~c | z;
            GE:      taken = n == v;
            LT:      taken = n != v;
            GT:      taken = ~z & (n == v);
            LE:      taken = z | (n != v);
            default: taken = 1'b1;
        endcase
    end
endmodule

// File: rtl/flags_branch_unit.sv
// flags_branch_unit: NZCV register, branch resolution with registered redirect,
// wrong-path shadow squash and the EX/MEM result register
module flags_branch_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int SHADOW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_set_flags,
    input  logic [1:0]        ex_br_type,
    input  logic              ex_cbnz,
    input  logic [3:0]        ex_cond,
    input  logic [DATA_W-1:0] ex_br_target,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_negative,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carry_out,
    output logic [3:0]        flags_q,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              squash_active,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [4:0]        mem_rd,
    output logic              mem_reg_write
);
    typedef enum logic {S_IDLE, S_SHADOW} state_e;
    localparam logic [1:0] SHADOW_INIT = 2'(SHADOW);

    state_e     state;
    logic [1:0] cnt;
    logic       commit, taken, cond_ok, cb_ok;
    br_type_e   br;

    cond_eval u_cond (.cond(ex_cond), .flags(flags_q), .taken(cond_ok));

    assign br            = br_type_e'(ex_br_type);
    assign commit        = ex_valid & ~stall & ~flush & (state == S_IDLE);
    assign cb_ok         = ex_cbnz ^ alu_zero;
    assign taken         = commit & ((br == BR_B) | ((br == BR_CBZ) & cb_ok) | ((br == BR_COND) & cond_ok));
    assign squash_active = state == S_SHADOW;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            flags_q        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
        end else if (flush) begin
            state          <= S_IDLE;
            cnt            <= '0;
            redirect_valid <= 1'b0;
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
        end else begin
            // the pulse is one cycle wide even when the pipe is frozen
            redirect_valid <= taken;
            if (taken) redirect_pc <= ex_br_target;
            if (commit & ex_set_flags) flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
            if (!stall) begin
                mem_valid     <= commit;
                mem_result    <= alu_result;
                mem_rd        <= ex_rd;
                mem_reg_write <= commit & ex_reg_write;
                if (state == S_SHADOW) begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) state <= S_IDLE;
                end else if (taken) begin
                    state <= S_SHADOW;
                    cnt   <= SHADOW_INIT;
                end
            end
        end
    end
endmodule

// File: tb/tb_flags_branch_unit.sv
// tb_flags_branch_unit: directed scenarios plus random traffic checked against
// a cycle-level behavioural model of flags, redirects and squash slots
module tb_flags_branch_unit;
    localparam int DW = 64;
    localparam int SH = 2;

    logic          clk = 1'b0;
    logic          reset, stall, flush, ex_valid, ex_set_flags, ex_cbnz, ex_reg_write;
    logic [1:0]    ex_br_type;
    logic [3:0]    ex_cond;
    logic [DW-1:0] ex_br_target, alu_result;
    logic [4:0]    ex_rd;
    logic          alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic [3:0]    flags_q;
    logic          redirect_valid, squash_active, mem_valid, mem_reg_write;
    logic [DW-1:0] redirect_pc, mem_result;
    logic [4:0]    mem_rd;

    always #5 clk = ~clk;

    flags_branch_unit #(.DATA_W(DW), .SHADOW(SH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_set_flags(ex_set_flags), .ex_br_type(ex_br_type),
        .ex_cbnz(ex_cbnz), .ex_cond(ex_cond), .ex_br_target(ex_br_target),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .alu_result(alu_result),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .flags_q(flags_q), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .squash_active(squash_active), .mem_valid(mem_valid), .mem_result(mem_result),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference state: m_left counts wrong-path slots still to be squashed
    logic [3:0]    m_flags;
    logic          m_rv, m_mv, m_mrw;
    logic [DW-1:0] m_rpc, m_mres;
    logic [4:0]    m_mrd;
    int            m_left;

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_flags = 0; m_rv = 0; m_rpc = 0; m_left = 0;
        m_mv = 0; m_mres = 0; m_mrd = 0; m_mrw = 0;
    endtask

    task automatic model_step();
        logic commit, take;
        commit = ex_valid && !stall && !flush && (m_left == 0);
        take = commit && ((ex_br_type == 2'd1)
            || (ex_br_type == 2'd2 && (ex_cbnz ? !alu_zero : alu_zero))
            || (ex_br_type == 2'd3 && cond_ref(ex_cond, m_flags)));
        if (flush) begin
            m_left = 0; m_rv = 0; m_mv = 0; m_mrw = 0;
        end else begin
            m_rv = take;
            if (take) m_rpc = ex_br_target;
            if (commit && ex_set_flags) m_flags = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
            if (!stall) begin
                m_mv = commit; m_mres = alu_result; m_mrd = ex_rd; m_mrw = commit && ex_reg_write;
                if (m_left > 0) m_left--;
                else if (take) m_left = SH;
            end
        end
    endtask

    task automatic compare_all();
        check("flags_q", flags_q, m_flags);
        check("redirect_valid", redirect_valid, m_rv);
        check("redirect_pc", redirect_pc, m_rpc);
        check("squash_active", squash_active, m_left > 0);
        check("mem_valid", mem_valid, m_mv);
        check("mem_result", mem_result, m_mres);
        check("mem_rd", mem_rd, m_mrd);
        check("mem_reg_write", mem_reg_write, m_mrw);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_in();
        stall = 0; flush = 0; ex_valid = 0; ex_set_flags = 0; ex_br_type = 0; ex_cbnz = 0;
        ex_cond = 0; ex_br_target = 0; ex_rd = 0; ex_reg_write = 0; alu_result = 0;
        alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
    endtask

    task automatic set_alu(input logic n, input logic z, input logic c, input logic v);
        alu_negative = n; alu_zero = z; alu_carry_out = c; alu_overflow = v;
    endtask

    task automatic rand_in();
        stall        = $urandom_range(0, 4) == 0;
        flush        = $urandom_range(0, 19) == 0;
        ex_valid     = $urandom_range(0, 9) < 8;
        ex_set_flags = $urandom_range(0, 2) == 0;
        ex_br_type   = 2'($urandom_range(0, 3));
        ex_cbnz      = 1'($urandom);
        ex_cond      = 4'($urandom);
        ex_br_target = {$urandom, $urandom};
        ex_rd        = 5'($urandom);
        ex_reg_write = 1'($urandom);
        alu_result   = {$urandom, $urandom};
        set_alu(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        reset = 0;
        rand_in();
        #1;
        model_reset();
        compare_all();
        repeat (3) begin
            @(posedge clk);
            #1;
            rand_in();
            compare_all();
        end
        reset = 1;
        clear_in();
    endtask

    initial begin
        clear_in();
        reset = 1;
        #2;
        do_reset();
        check("reset_flags", flags_q, 4'b0000);

        // compare then B.EQ
        ex_valid = 1; ex_set_flags = 1; ex_reg_write = 1; ex_rd = 5'd3; set_alu(0, 1, 1, 0);
        alu_result = 64'h5;
        cycle();
        check("subs_flags", flags_q, 4'b0110);
        clear_in(); ex_valid = 1; ex_br_type = 2'd3; ex_cond = 4'd0; ex_br_target = 64'h1000;
        cycle();
        check("beq_redirect", redirect_valid, 1'b1);
        check("beq_pc", redirect_pc, 64'h1000);
        clear_in(); ex_valid = 1; ex_reg_write = 1;
        cycle();
        check("beq_slot1", mem_valid, 1'b0);
        check("beq_pulse", redirect_valid, 1'b0);
        cycle();
        check("beq_slot2", mem_valid, 1'b0);
        cycle();
        check("beq_slot3", mem_valid, 1'b1);

        // signed compare: N=1 V=0
        clear_in(); ex_valid = 1; ex_set_flags = 1; set_alu(1, 0, 0, 0);
        cycle();
        check("neg_flags", flags_q, 4'b1000);
        clear_in(); ex_valid = 1; ex_br_type = 2'd3; ex_cond = 4'd11; ex_br_target = 64'h2000;
        cycle();
        check("blt_taken", redirect_valid, 1'b1);
        clear_in();
        cycle();
        cycle();
        ex_valid = 1; ex_br_type = 2'd3; ex_cond = 4'd10; ex_br_target = 64'h2400;
        cycle();
        check("bge_not_taken", redirect_valid, 1'b0);
        check("bge_mem_valid", mem_valid, 1'b1);

        // CBNZ / CBZ
        clear_in(); ex_valid = 1; ex_br_type = 2'd2; ex_cbnz = 1; ex_br_target = 64'h3000;
        cycle();
        check("cbnz_taken", redirect_valid, 1'b1);
        check("cbnz_flags", flags_q, 4'b1000);
        clear_in();
        cycle();
        cycle();
        ex_valid = 1; ex_br_type = 2'd2; ex_cbnz = 0;
        cycle();
        check("cbz_not_taken", redirect_valid, 1'b0);
        check("cbz_flags", flags_q, 4'b1000);

        // stall during shadow
        clear_in(); ex_valid = 1; ex_br_type = 2'd1; ex_br_target = 64'h4000;
        cycle();
        check("b_taken", redirect_valid, 1'b1);
        clear_in(); ex_valid = 1; stall = 1;
        repeat (3) begin
            cycle();
            check("stall_squash", squash_active, 1'b1);
            check("stall_pulse", redirect_valid, 1'b0);
        end
        stall = 0;
        cycle();
        check("shadow_left1", squash_active, 1'b1);
        cycle();
        check("shadow_done", squash_active, 1'b0);

        // flush beats a would-be-taken branch
        clear_in(); ex_valid = 1; ex_br_type = 2'd1; flush = 1; ex_set_flags = 1; set_alu(0, 1, 0, 0);
        cycle();
        check("flush_redirect", redirect_valid, 1'b0);
        check("flush_squash", squash_active, 1'b0);
        check("flush_mem_valid", mem_valid, 1'b0);
        check("flush_flags", flags_q, 4'b1000);

        // asynchronous reset while in the shadow
        clear_in(); ex_valid = 1; ex_br_type = 2'd1; ex_br_target = 64'h5000;
        cycle();
        clear_in();
        cycle();
        check("pre_reset_squash", squash_active, 1'b1);
        #2;
        reset = 0;
        #1;
        model_reset();
        compare_all();
        check("reset_mid_shadow", squash_active, 1'b0);
        @(posedge clk);
        #1;
        reset = 1;
        cycle();

        repeat (3000) begin
            rand_in();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/flags_branch_unit.md
Name: flags_branch_unit

Overview:
Execute-stage back end that sits directly downstream of the 64-bit ALU. It owns the architectural NZCV flag register, updated by flag-setting instructions (ADDS/SUBS). It resolves B, CBZ/CBNZ and B.cond, issues a registered PC redirect, and squashes the younger wrong-path instructions. It also registers the ALU result into the EX/MEM pipeline register.

Parameters:
DATA_W, 64, datapath width (ALU result, PCs)
SHADOW, 2, number of non-stalled EX slots squashed after a taken branch (1..3)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset: reset=0 clears all state immediately
stall  in  1  hold all state this cycle (pipeline freeze)
flush  in  1  external kill (exception/restart); has priority over everything except reset
ex_valid  in  1  EX slot holds a real instruction
ex_set_flags  in  1  instruction writes NZCV (ADDS/SUBS)
ex_br_type  in  2  0=none, 1=B (unconditional), 2=CBZ/CBNZ, 3=B.cond
ex_cbnz  in  1  for type 2: 1=CBNZ, 0=CBZ
ex_cond  in  4  ARM condition code for B.cond
ex_br_target  in  DATA_W  computed branch target
ex_rd  in  5  destination register index
ex_reg_write  in  1  instruction writes the register file
alu_result  in  DATA_W  ALU result
alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1 each  ALU flags
flags_q  out  4  committed {N,Z,C,V}
redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  out  DATA_W  branch target
squash_active  out  1  block is in SHADOW (upstream kills its ID slot)
mem_valid  out  1  EX/MEM register holds a valid instruction
mem_result  out  DATA_W  registered alu_result
mem_rd  out  5  registered ex_rd
mem_reg_write  out  1  registered ex_reg_write, gated by commit

Behaviour:
- Reset values: flags_q=0, redirect_valid=0, redirect_pc=0, squash_active=0, mem_valid=0, mem_result=0, mem_rd=0, mem_reg_write=0; FSM=IDLE, shadow counter=0.
- commit = ex_valid & ~stall & ~flush & (state==IDLE).
- Flags: on commit & ex_set_flags, flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow} at the clock edge. C follows ARM convention: on subtract, C=1 means no borrow; the raw ALU carry is used unchanged. Otherwise flags_q holds.
- B.cond evaluates the current flags_q (from older instructions), never the same-cycle ALU flags.
- Conditions: EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL(14) and 15 are always true.
- CBZ is taken when alu_zero=1; CBNZ is taken when alu_zero=0. The ALU passes B through for these.
- taken = commit & (type1 | type2 cond | type3 cond). It is combinational and internal only.
- Redirect latency 1: the edge after taken sets redirect_valid=1 and redirect_pc=ex_br_target. redirect_valid clears on the next edge unconditionally; stall does not stretch the pulse.
- FSM states:
  - IDLE -> SHADOW on taken; counter loads SHADOW.
  - SHADOW: each non-stalled cycle decrements the counter. At 1 -> IDLE. EX instructions are not committed, so no flags, mem_valid or branch. squash_active=1.
  - flush in any state -> IDLE, counter=0, redirect_valid=0 next edge.
- EX/MEM register:
  - non-stalled edge: mem_valid <= commit; mem_result/mem_rd <= inputs; mem_reg_write <= commit & ex_reg_write.
  - stall: hold all values.
  - flush: mem_valid=0 and mem_reg_write=0.
- Simultaneous stall+flush: flush wins. A taken branch with ex_set_flags never occurs (ISA); if it does, both actions apply.
- Reset mid-SHADOW returns to IDLE with no pending redirect.

Decomposition:
- Package cpu_pkg holds:
  - br_type_e enum {BR_NONE, BR_B, BR_CBZ, BR_COND}
  - cond code localparams EQ..AL (4'h0..4'hE)
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- Sub-module cond_eval: purely combinational, inputs 4-bit cond and 4-bit flags, output taken. It is reused later by conditional-select instructions.

Test Plan:
- Reset: hold reset=0 with random inputs, then release -> all outputs 0; flags_q=4'b0000 throughout.
- Compare then branch: SUBS with ALU flags N0 Z1 C1 V0, then B.EQ (cond 0) -> flags_q=4'b0110 after the edge; B.EQ taken; redirect_valid pulses once with redirect_pc=target; the next 2 ex_valid slots give mem_valid=0.
- Signed compare: flags {N=1,V=0} with B.LT (cond 11) -> taken. Same flags with B.GE (cond 10) -> not taken, redirect_valid stays 0, mem_valid=1.
- CBNZ with alu_zero=0 -> taken. CBZ with alu_zero=0 -> not taken. Neither modifies flags_q.
- Stall during SHADOW: 3 stall cycles after redirect -> counter frozen, squash_active=1 until 2 non-stalled cycles elapse; redirect_valid is high for exactly 1 cycle.
- Flush in the same cycle as a would-be-taken B -> no redirect, FSM IDLE, mem_valid=0, flags_q unchanged.
